// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for a five-stage pipeline: load-use stalls, taken-branch flushes and memory-wait freezes.
// Define HAZARD_PERF_CNT_EN to add the 32-bit StallCount/FlushCount performance outputs.
module pipeline_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_read_ex,
  input  logic [4:0]  i_rt_ex,
  input  logic [4:0]  i_rs_id,
  input  logic [4:0]  i_rt_id,
  input  logic        i_uses_rt_id,
  input  logic        i_branch_taken_mem,
  input  logic        i_mem_req_mem,
  input  logic        i_mem_ack,
  output logic        o_pc_write,
  output logic        o_if_id_write,
  output logic        o_id_ex_bubble,
  output logic        o_flush_if_id,
  output logic        o_flush_id_ex,
  output logic        o_flush_ex_mem,
  output logic        o_stall_all,
  output logic        o_mem_timeout,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] o_stall_count,
  output logic [31:0] o_flush_count,
`endif
  output logic [1:0]  o_state
);

  localparam logic [1:0] S_RUN        = 2'b00;
  localparam logic [1:0] S_LOAD_STALL = 2'b01;
  localparam logic [1:0] S_FLUSH      = 2'b10;
  localparam logic [1:0] S_MEM_WAIT   = 2'b11;

  localparam logic [7:0] TIMEOUT_CNT  = 8'(MEM_TIMEOUT);

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic [7:0] r_wait_cnt;
  logic       r_timeout;

  logic w_load_use;
  logic w_in_wait;
  logic w_lu_masked;
  logic w_mem_stall;
  logic w_branch;
  logic w_lu_stall;
  logic w_pc_write;
  logic w_timeout_hit;

  assign w_load_use = i_mem_read_ex && (i_rt_ex != 5'd0) &&
                      ((i_rt_ex == i_rs_id) || (i_uses_rt_id && (i_rt_ex == i_rt_id)));

  assign w_in_wait   = (r_state == S_MEM_WAIT);
  assign w_lu_masked = (r_state == S_LOAD_STALL) || (r_state == S_FLUSH);

  // Events are gated by reset so every control output sits at its default while reset is held.
  assign w_mem_stall = i_rst_n && (w_in_wait ? !i_mem_ack : (i_mem_req_mem && !i_mem_ack));
  assign w_branch    = i_rst_n && !w_mem_stall && i_branch_taken_mem;
  assign w_lu_stall  = i_rst_n && !w_mem_stall && !i_branch_taken_mem &&
                       w_load_use && !w_lu_masked;

  assign w_pc_write  = !(w_mem_stall || w_lu_stall);

  assign o_pc_write     = w_pc_write;
  assign o_if_id_write  = w_pc_write;
  assign o_id_ex_bubble = w_lu_stall;
  assign o_flush_if_id  = w_branch;
  assign o_flush_id_ex  = w_branch;
  assign o_flush_ex_mem = w_branch;
  assign o_stall_all    = w_mem_stall;
  assign o_state        = r_state;

  always_comb begin
    w_state_next = S_RUN;
    if (w_mem_stall) begin
      w_state_next = S_MEM_WAIT;
    end else if (w_branch) begin
      w_state_next = S_FLUSH;
    end else if (w_lu_stall) begin
      w_state_next = S_LOAD_STALL;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The count equals (MEM_WAIT cycles elapsed - 1) during each wait cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= 8'd0;
    end else if (!w_in_wait && (w_state_next == S_MEM_WAIT)) begin
      r_wait_cnt <= 8'd0;
    end else if (w_in_wait && (r_wait_cnt != 8'hFF)) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  assign w_timeout_hit = w_in_wait && (r_wait_cnt == TIMEOUT_CNT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timeout <= 1'b0;
    end else if (w_timeout_hit) begin
      r_timeout <= 1'b1;
    end
  end

  // The flag is visible in the very cycle the count matches, then held by the register.
  assign o_mem_timeout = r_timeout || w_timeout_hit;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_count <= 32'd0;
      r_flush_count <= 32'd0;
    end else begin
      if (!w_pc_write) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
      if (w_branch) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign o_stall_count = r_stall_count;
  assign o_flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: expected control vectors are queued per step and checked at the falling edge.
module tb_pipeline_hazard_controller;

  localparam logic [1:0] RUN = 2'b00;
  localparam logic [1:0] LS  = 2'b01;
  localparam logic [1:0] FL  = 2'b10;
  localparam logic [1:0] MW  = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       mem_read_ex;
  logic [4:0] rt_ex;
  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic       uses_rt_id;
  logic       branch_taken_mem;
  logic       mem_req_mem;
  logic       mem_ack;
  logic       pc_write;
  logic       if_id_write;
  logic       id_ex_bubble;
  logic       flush_if_id;
  logic       flush_id_ex;
  logic       flush_ex_mem;
  logic       stall_all;
  logic       mem_timeout;
  logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count;
  logic [31:0] flush_count;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_stall_cnt = 0;
  int exp_flush_cnt = 0;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } exp_t;

  exp_t sb[$];

  pipeline_hazard_controller #(.MEM_TIMEOUT(4)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_mem_read_ex      (mem_read_ex),
    .i_rt_ex            (rt_ex),
    .i_rs_id            (rs_id),
    .i_rt_id            (rt_id),
    .i_uses_rt_id       (uses_rt_id),
    .i_branch_taken_mem (branch_taken_mem),
    .i_mem_req_mem      (mem_req_mem),
    .i_mem_ack          (mem_ack),
    .o_pc_write         (pc_write),
    .o_if_id_write      (if_id_write),
    .o_id_ex_bubble     (id_ex_bubble),
    .o_flush_if_id      (flush_if_id),
    .o_flush_id_ex      (flush_id_ex),
    .o_flush_ex_mem     (flush_ex_mem),
    .o_stall_all        (stall_all),
    .o_mem_timeout      (mem_timeout),
`ifdef HAZARD_PERF_CNT_EN
    .o_stall_count      (stall_count),
    .o_flush_count      (flush_count),
`endif
    .o_state            (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {pc, if_id, bubble, flush[if_id,id_ex,ex_mem], stall_all, timeout, state}
  function automatic logic [9:0] mk(input logic pc, input logic ifid, input logic bub,
                                    input logic [2:0] fl, input logic stall,
                                    input logic tmo, input logic [1:0] st);
    return {pc, ifid, bub, fl, stall, tmo, st};
  endfunction

  task automatic drive(input logic mr, input logic [4:0] rte, input logic [4:0] rs,
                       input logic [4:0] rt, input logic uses, input logic br,
                       input logic req, input logic ack);
    mem_read_ex      = mr;
    rt_ex            = rte;
    rs_id            = rs;
    rt_id            = rt;
    uses_rt_id       = uses;
    branch_taken_mem = br;
    mem_req_mem      = req;
    mem_ack          = ack;
  endtask

  task automatic check(input string tag, input logic [9:0] e);
    logic [9:0] obs;
    obs = {pc_write, if_id_write, id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem,
           stall_all, mem_timeout, state};
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
    $display("step %-14s observed=%b expected=%b", tag, obs, e);
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    assert ((stall_count === 32'(exp_stall_cnt)) && (flush_count === 32'(exp_flush_cnt))) else begin
      failures++;
      $error("FAIL %s_perf observed=%0d/%0d expected=%0d/%0d", tag, stall_count, flush_count,
             exp_stall_cnt, exp_flush_cnt);
    end
`endif
  endtask

  // Inputs are already driven (just after a rising edge); outputs are checked at the falling edge.
  task automatic step(input string tag, input logic [9:0] e);
    exp_t item;
    sb.push_back('{tag: tag, exp: e});
    @(negedge clk);
    item = sb.pop_front();
    check(item.tag, item.exp);
    if (item.exp[9] == 1'b0) exp_stall_cnt++;
    if (item.exp[6:4] == 3'b111) exp_flush_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("reset", mk(1, 1, 0, 3'b000, 0, 0, RUN));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load-use on rs, then one LOAD_STALL cycle
    drive(1, 8, 8, 0, 0, 0, 0, 0);
    step("lu_stall",     mk(0, 0, 1, 3'b000, 0, 0, RUN));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("lu_state01",   mk(1, 1, 0, 3'b000, 0, 0, LS));
    step("lu_back_run",  mk(1, 1, 0, 3'b000, 0, 0, RUN));

    // Load into $0 never stalls
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step("load_r0",      mk(1, 1, 0, 3'b000, 0, 0, RUN));
    step("load_r0_hold", mk(1, 1, 0, 3'b000, 0, 0, RUN));

    // Load-use on rt held for two cycles: only one stall cycle
    drive(1, 5, 3, 5, 1, 0, 0, 0);
    step("lu_rt",        mk(0, 0, 1, 3'b000, 0, 0, RUN));
    step("lu_rt_masked", mk(1, 1, 0, 3'b000, 0, 0, LS));
    drive(1, 5, 3, 5, 0, 0, 0, 0);
    step("rt_unused",    mk(1, 1, 0, 3'b000, 0, 0, RUN));

    // Branch discards a coincident load-use; FLUSH masks detection
    drive(1, 8, 8, 0, 0, 1, 0, 0);
    step("br_flush",     mk(1, 1, 0, 3'b111, 0, 0, RUN));
    drive(1, 8, 8, 0, 0, 0, 0, 0);
    step("flush_masked", mk(1, 1, 0, 3'b000, 0, 0, FL));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("flush_run",    mk(1, 1, 0, 3'b000, 0, 0, RUN));

    // Plain memory wait: three stall cycles, released by ack
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step("mw_enter",     mk(0, 0, 0, 3'b000, 1, 0, RUN));
    step("mw_1",         mk(0, 0, 0, 3'b000, 1, 0, MW));
    step("mw_2",         mk(0, 0, 0, 3'b000, 1, 0, MW));
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    step("mw_ack",       mk(1, 1, 0, 3'b000, 0, 0, MW));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("mw_run",       mk(1, 1, 0, 3'b000, 0, 0, RUN));

    // Branch during memory wait waits for ack
    drive(1, 8, 8, 0, 0, 1, 1, 0);
    step("mw_over_br",   mk(0, 0, 0, 3'b000, 1, 0, RUN));
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    step("mw_br_hold",   mk(0, 0, 0, 3'b000, 1, 0, MW));
    drive(1, 8, 8, 0, 0, 1, 1, 1);
    step("mw_ack_br",    mk(1, 1, 0, 3'b111, 0, 0, MW));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("ack_br_flush", mk(1, 1, 0, 3'b000, 0, 0, FL));
    step("ack_br_run",   mk(1, 1, 0, 3'b000, 0, 0, RUN));

    // Load-use acted on in the ack cycle
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step("mw_lu_enter",  mk(0, 0, 0, 3'b000, 1, 0, RUN));
    drive(1, 8, 8, 0, 0, 0, 1, 1);
    step("mw_ack_lu",    mk(0, 0, 1, 3'b000, 0, 0, MW));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("ack_lu_ls",    mk(1, 1, 0, 3'b000, 0, 0, LS));
    step("ack_lu_run",   mk(1, 1, 0, 3'b000, 0, 0, RUN));

    // Timeout (MEM_TIMEOUT=4): flag from the 5th MEM_WAIT cycle, sticky afterwards
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step("to_enter",     mk(0, 0, 0, 3'b000, 1, 0, RUN));
    for (int k = 1; k <= 5; k++) begin
      step($sformatf("to_mw%0d", k), mk(0, 0, 0, 3'b000, 1, (k == 5), MW));
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    step("to_ack",       mk(1, 1, 0, 3'b000, 0, 1, MW));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("to_sticky",    mk(1, 1, 0, 3'b000, 0, 1, RUN));

    // Asynchronous reset in the middle of a memory wait
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step("rs_enter",     mk(0, 0, 0, 3'b000, 1, 1, RUN));
    step("rs_mw",        mk(0, 0, 0, 3'b000, 1, 1, MW));
    #2;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    exp_stall_cnt = 0;
    exp_flush_cnt = 0;
    #1;
    check("rst_async",   mk(1, 1, 0, 3'b000, 0, 0, RUN));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("rst_release",  mk(1, 1, 0, 3'b000, 0, 0, RUN));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
